dmem_port_arbiter: RTL and testbench

- Round-robin arbiter that shares the single data-memory controller port among the protocol controllers (SPI, UART, I2C by default).
- Sits between the protocol controllers and the core's `con_addr` / `con_write` / `con_in` / `con_out` port.
- Issues at most one memory access per cycle and routes the synchronous-read data back to the requester that was granted.

---
 rtl/dmem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_dmem_port_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous-read data-memory port among N_REQ protocol controllers.
// Optional burst locking is compiled in with `define ARB_LOCK_EN (bounded by MAX_LOCK grants).
module dmem_port_arbiter #(
  parameter int N_REQ    = 3,
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic [N_REQ-1:0]         req,
  input  logic [4*N_REQ-1:0]       req_wr,
  input  logic [ADDR_W*N_REQ-1:0]  req_addr,
  input  logic [DATA_W*N_REQ-1:0]  req_wdata,
  input  logic [N_REQ-1:0]         req_lock,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic [ADDR_W-1:0]        con_addr,
  output logic [3:0]               con_write,
  output logic [DATA_W-1:0]        con_in,
  input  logic [DATA_W-1:0]        con_out,
  output logic                     busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  rvalid_q, rvalid_d;
  logic [N_REQ-1:0]  elig;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  hi_idx, lo_idx, win_idx;
  logic              hi_found, lo_found, win_found;
  logic [ADDR_W-1:0] con_addr_q, con_addr_d;
  logic [3:0]        con_write_q, con_write_d;
  logic [DATA_W-1:0] con_in_q, con_in_d;

`ifdef ARB_LOCK_EN
  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             lock_hit, lock_max;
`else
  logic unused_lock;
  assign unused_lock = (^req_lock) ^ (MAX_LOCK > 0);
`endif

  always_comb begin
    // A requester granted this cycle is masked so it cannot be issued twice.
    elig     = req & ~gnt_q;
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    // Rotation: first eligible index above ptr, otherwise first at or below ptr.
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (elig[j] && !hi_found && (j > 32'(ptr_q))) begin
        hi_found = 1'b1;
        hi_idx   = PTR_W'(j);
      end
      if (elig[j] && !lo_found && (j <= 32'(ptr_q))) begin
        lo_found = 1'b1;
        lo_idx   = PTR_W'(j);
      end
    end
    win_found = hi_found | lo_found;
    win_idx   = hi_found ? hi_idx : lo_idx;

`ifdef ARB_LOCK_EN
    // ptr_q always names the requester shown on gnt, so a locked holder re-wins via ptr_q.
    lock_hit   = |(gnt_q & req & req_lock);
    lock_max   = (lock_cnt_q == CNT_W'(MAX_LOCK - 1));
    lock_cnt_d = '0;
    if (lock_hit && !lock_max) begin
      win_found  = 1'b1;
      win_idx    = ptr_q;
      lock_cnt_d = lock_cnt_q + CNT_W'(1);
    end
`endif

    gnt_d       = '0;
    con_write_d = '0;
    con_addr_d  = con_addr_q;
    con_in_d    = con_in_q;
    ptr_d       = ptr_q;
    if (win_found) begin
      ptr_d = win_idx;
      for (int unsigned j = 0; j < N_REQ; j++) begin
        if (PTR_W'(j) == win_idx) begin
          gnt_d[j]    = 1'b1;
          con_addr_d  = req_addr[ADDR_W*j +: ADDR_W];
          con_write_d = req_wr[4*j +: 4];
          con_in_d    = req_wdata[DATA_W*j +: DATA_W];
        end
      end
    end

    rvalid_d = (con_write_q == 4'b0000) ? gnt_q : '0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      gnt_q       <= '0;
      rvalid_q    <= '0;
      ptr_q       <= PTR_W'(N_REQ - 1);
      con_addr_q  <= '0;
      con_write_q <= '0;
      con_in_q    <= '0;
`ifdef ARB_LOCK_EN
      lock_cnt_q  <= '0;
`endif
    end else begin
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      ptr_q       <= ptr_d;
      con_addr_q  <= con_addr_d;
      con_write_q <= con_write_d;
      con_in_q    <= con_in_d;
`ifdef ARB_LOCK_EN
      lock_cnt_q  <= lock_cnt_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign rvalid    = rvalid_q;
  assign rdata     = con_out;
  assign con_addr  = con_addr_q;
  assign con_write = con_write_q;
  assign con_in    = con_in_q;
  assign busy      = (|gnt_q) | (|rvalid_q);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter with a byte-writable synchronous-read memory model.
module tb_dmem_port_arbiter;
  localparam int N  = 3;
  localparam int AW = 12;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            nrst = 1'b0;
  logic [N-1:0]    req = '0;
  logic [4*N-1:0]  req_wr = '0;
  logic [AW*N-1:0] req_addr = '0;
  logic [DW*N-1:0] req_wdata = '0;
  logic [N-1:0]    req_lock = '0;
  logic [N-1:0]    gnt, rvalid;
  logic [DW-1:0]   rdata;
  logic [AW-1:0]   con_addr;
  logic [3:0]      con_write;
  logic [DW-1:0]   con_in;
  logic [DW-1:0]   con_out;
  logic            busy;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] mem [0:4095];
  logic        pre_we = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [31:0] pre_data = '0;

  dmem_port_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(4)) dut (
    .clk(clk), .nrst(nrst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_lock(req_lock), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .con_addr(con_addr), .con_write(con_write), .con_in(con_in),
    .con_out(con_out), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    for (int b = 0; b < 4; b++)
      if (con_write[b]) mem[con_addr][8*b +: 8] <= con_in[8*b +: 8];
    con_out <= mem[con_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    tick();
    pre_we   = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [3:0] wr, input logic [11:0] a, input logic [31:0] d);
    req_wr[4*i +: 4]     = wr;
    req_addr[AW*i +: AW] = a;
    req_wdata[DW*i +: DW] = d;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++; if (gnt !== 3'b000) begin tests_failed++; $display("FAIL reset_gnt got %b exp 000", gnt); end
    tests_run++; if (rvalid !== 3'b000) begin tests_failed++; $display("FAIL reset_rvalid got %b exp 000", rvalid); end
    tests_run++; if (con_write !== 4'b0000) begin tests_failed++; $display("FAIL reset_con_write got %b exp 0000", con_write); end
    tests_run++; if (con_addr !== 12'h000) begin tests_failed++; $display("FAIL reset_con_addr got %h exp 000", con_addr); end
    tests_run++; if (con_in !== 32'h0) begin tests_failed++; $display("FAIL reset_con_in got %h exp 0", con_in); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b exp 0", busy); end
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    set_req(1, 4'b0000, 12'h010, 32'h0);
    req = 3'b010;
    tick();
    req = 3'b000;
    @(negedge clk);
    tests_run++; if (gnt !== 3'b010) begin tests_failed++; $display("FAIL rd_gnt got %b exp 010", gnt); end
    tests_run++; if (con_addr !== 12'h010) begin tests_failed++; $display("FAIL rd_con_addr got %h exp 010", con_addr); end
    tests_run++; if (con_write !== 4'b0000) begin tests_failed++; $display("FAIL rd_con_write got %b exp 0000", con_write); end
    tests_run++; if (rvalid !== 3'b000) begin tests_failed++; $display("FAIL rd_early_rvalid got %b exp 000", rvalid); end
    tick();
    @(negedge clk);
    tests_run++; if (rvalid !== 3'b010) begin tests_failed++; $display("FAIL rd_rvalid got %b exp 010", rvalid); end
    tests_run++; if (rdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL rd_rdata got %h exp deadbeef", rdata); end
    tests_run++; if (gnt !== 3'b000) begin tests_failed++; $display("FAIL rd_gnt_after got %b exp 000", gnt); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL rd_busy got %b exp 1", busy); end
    tick();
    @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rd_idle_busy got %b exp 0", busy); end
    tests_run++; if (rvalid !== 3'b000) begin tests_failed++; $display("FAIL rd_idle_rvalid got %b exp 000", rvalid); end
    tick();
  endtask

  task automatic test_single_write();
    set_req(2, 4'b0011, 12'h020, 32'h0000ABCD);
    req = 3'b100;
    tick();
    req = 3'b000;
    set_req(2, 4'b0000, 12'h020, 32'h0);
    @(negedge clk);
    tests_run++; if (gnt !== 3'b100) begin tests_failed++; $display("FAIL wr_gnt got %b exp 100", gnt); end
    tests_run++; if (con_write !== 4'b0011) begin tests_failed++; $display("FAIL wr_con_write got %b exp 0011", con_write); end
    tests_run++; if (con_addr !== 12'h020) begin tests_failed++; $display("FAIL wr_con_addr got %h exp 020", con_addr); end
    tests_run++; if (con_in !== 32'h0000ABCD) begin tests_failed++; $display("FAIL wr_con_in got %h exp 0000abcd", con_in); end
    tick();
    @(negedge clk);
    tests_run++; if (con_write !== 4'b0000) begin tests_failed++; $display("FAIL wr_con_write_after got %b exp 0000", con_write); end
    tests_run++; if (rvalid !== 3'b000) begin tests_failed++; $display("FAIL wr_rvalid got %b exp 000", rvalid); end
    tests_run++; if (mem[12'h020] !== 32'h1234ABCD) begin tests_failed++; $display("FAIL wr_mem got %h exp 1234abcd", mem[12'h020]); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [2:0]  exp_g;
    logic [2:0]  exp_v;
    logic [31:0] exp_d;
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 4'b0000, 12'(12'h100 + i), 32'h0);
    req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      tick();
      @(negedge clk);
      exp_g = 3'b001 << (k % 3);
      tests_run++; if (gnt !== exp_g) begin tests_failed++; $display("FAIL rr_gnt step %0d got %b exp %b", k, gnt, exp_g); end
      if (k > 0) begin
        exp_v = 3'b001 << ((k - 1) % 3);
        exp_d = 32'h11111111 * (((k - 1) % 3) + 1);
        tests_run++; if (rvalid !== exp_v) begin tests_failed++; $display("FAIL rr_rvalid step %0d got %b exp %b", k, rvalid, exp_v); end
        tests_run++; if (rdata !== exp_d) begin tests_failed++; $display("FAIL rr_rdata step %0d got %h exp %h", k, rdata, exp_d); end
      end
    end
    req = 3'b000;
    tick();
    @(negedge clk);
    tests_run++; if (rvalid !== 3'b100) begin tests_failed++; $display("FAIL rr_last_rvalid got %b exp 100", rvalid); end
    tests_run++; if (gnt !== 3'b000) begin tests_failed++; $display("FAIL rr_drain_gnt got %b exp 000", gnt); end
    tick();
    tick();
  endtask

  task automatic test_single_requester();
    logic [2:0] exp_g;
    logic [2:0] exp_v;
    set_req(0, 4'b0000, 12'h100, 32'h0);
    req = 3'b001;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      exp_g = (c % 2 == 1) ? 3'b001 : 3'b000;
      exp_v = (c >= 2 && c % 2 == 0) ? 3'b001 : 3'b000;
      tests_run++; if (gnt !== exp_g) begin tests_failed++; $display("FAIL solo_gnt cyc %0d got %b exp %b", c, gnt, exp_g); end
      tests_run++; if (rvalid !== exp_v) begin tests_failed++; $display("FAIL solo_rvalid cyc %0d got %b exp %b", c, rvalid, exp_v); end
      if (c >= 1) begin
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL solo_busy cyc %0d got %b exp 1", c, busy); end
      end
      tick();
      if (c == 5) req = 3'b000;
    end
    tick();
  endtask

  task automatic test_reset_mid();
    set_req(1, 4'b0000, 12'h010, 32'h0);
    req = 3'b010;
    tick();
    nrst = 1'b0;
    req  = 3'b000;
    @(negedge clk);
    tests_run++; if (gnt !== 3'b000) begin tests_failed++; $display("FAIL rstmid_gnt got %b exp 000", gnt); end
    tests_run++; if (con_write !== 4'b0000) begin tests_failed++; $display("FAIL rstmid_con_write got %b exp 0000", con_write); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    tests_run++; if (con_addr !== 12'h000) begin tests_failed++; $display("FAIL rstmid_con_addr got %h exp 000", con_addr); end
    nrst = 1'b1;
    tick();
    @(negedge clk);
    tests_run++; if (rvalid !== 3'b000) begin tests_failed++; $display("FAIL rstmid_rvalid got %b exp 000", rvalid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy2 got %b exp 0", busy); end
    set_req(0, 4'b0000, 12'h100, 32'h0);
    req = 3'b011;
    tick();
    @(negedge clk);
    tests_run++; if (gnt !== 3'b001) begin tests_failed++; $display("FAIL rstmid_restart_gnt got %b exp 001", gnt); end
    req = 3'b000;
    tick();
    tick();
    tick();
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    logic [2:0] lock_exp [6];
    lock_exp = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b001, 3'b010};
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    set_req(0, 4'b0000, 12'h100, 32'h0);
    set_req(1, 4'b0000, 12'h101, 32'h0);
    req_lock = 3'b010;
    req = 3'b010;
    tick();
    req = 3'b011;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      tests_run++; if (gnt !== lock_exp[c]) begin tests_failed++; $display("FAIL lock_gnt step %0d got %b exp %b", c, gnt, lock_exp[c]); end
      tick();
    end
    req = 3'b000;
    req_lock = 3'b000;
    tick();
    tick();
  endtask
`endif

  initial begin
    preload(12'h010, 32'hDEADBEEF);
    preload(12'h020, 32'h12345678);
    preload(12'h100, 32'h11111111);
    preload(12'h101, 32'h22222222);
    preload(12'h102, 32'h33333333);
    test_reset();
    test_single_read();
    test_single_write();
    test_round_robin();
    test_single_requester();
    test_reset_mid();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
